// File: rtl/reg_file_banked_if.sv
// Bus bundle for reg_file_banked: one write port, two read ports and save/restore control.
interface reg_file_banked_if #(
  parameter int W = 8,
  parameter int D = 4
);
  logic         RegWrite;
  logic [D-1:0] writeReg;
  logic [W-1:0] writeValue;
  logic [D-1:0] R1;
  logic [D-1:0] R2;
  logic [W-1:0] val1;
  logic [W-1:0] val2;
  logic         saveReq;
  logic         restoreReq;
  logic         busy;
  logic         done;
  logic         wrDropped;

  modport master (
    output RegWrite, writeReg, writeValue, R1, R2, saveReq, restoreReq,
    input  val1, val2, busy, done, wrDropped
  );

  modport slave (
    input  RegWrite, writeReg, writeValue, R1, R2, saveReq, restoreReq,
    output val1, val2, busy, done, wrDropped
  );
endinterface

// File: rtl/reg_file_banked.sv
// Two-bank register file with a sequential save (active->shadow) / restore (shadow->active) engine.
// Optional macro REG_FILE_BANKED_BYPASS_EN forwards an accepted write to matching read ports.
module reg_file_banked #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  reg_file_banked_if.slave   bus
);
  localparam int N = 1 << D;
  localparam logic [D-1:0] CNT_LAST = D'(N - 1);
  localparam logic [D-1:0] CNT_ONE  = D'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [D-1:0] r_cnt;
  logic [D-1:0] w_cnt_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic         r_wr_dropped;
  logic         w_dropped_nxt;
  logic         w_wr_accept;
  logic         w_save_copy;
  logic         w_restore_copy;

  logic [W-1:0] r_active [N];
  logic [W-1:0] r_shadow [N];

  // Next-state, copy strobes and pulse generation
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;
    w_dropped_nxt  = 1'b0;
    w_wr_accept    = 1'b0;
    w_save_copy    = 1'b0;
    w_restore_copy = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_accept = bus.RegWrite;
        // Save has priority; a simultaneous restore request is dropped.
        if (bus.saveReq) begin
          w_state_nxt = SAVE;
          w_cnt_nxt   = '0;
        end else if (bus.restoreReq) begin
          w_state_nxt = RESTORE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SAVE: begin
        w_save_copy   = 1'b1;
        w_dropped_nxt = bus.RegWrite;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      RESTORE: begin
        w_restore_copy = 1'b1;
        w_dropped_nxt  = bus.RegWrite;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Control state, index counter and output pulse registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done       <= w_done_nxt;
      r_wr_dropped <= w_dropped_nxt;
    end
  end

  // Bank storage: host writes and restore copies target active, save copies target shadow
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (w_wr_accept) begin
        r_active[bus.writeReg] <= bus.writeValue;
      end else if (w_restore_copy) begin
        r_active[r_cnt] <= r_shadow[r_cnt];
      end
      if (w_save_copy) begin
        r_shadow[r_cnt] <= r_active[r_cnt];
      end
    end
  end

`ifdef REG_FILE_BANKED_BYPASS_EN
  logic w_hit1;
  logic w_hit2;
  assign w_hit1   = w_wr_accept && (bus.R1 == bus.writeReg);
  assign w_hit2   = w_wr_accept && (bus.R2 == bus.writeReg);
  assign bus.val1 = w_hit1 ? bus.writeValue : r_active[bus.R1];
  assign bus.val2 = w_hit2 ? bus.writeValue : r_active[bus.R2];
`else
  assign bus.val1 = r_active[bus.R1];
  assign bus.val2 = r_active[bus.R2];
`endif

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.wrDropped = r_wr_dropped;
endmodule

// File: tb/tb_reg_file_banked.sv
// Directed bench for reg_file_banked: expected values queued at stimulus time and checked on output.
module tb_reg_file_banked;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic CLK = 1'b0;
  logic Reset;

  reg_file_banked_if #(.W(W), .D(D)) bus ();

  reg_file_banked #(.W(W), .D(D)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] exp);
    sb_q.push_back(exp);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic write_reg(input logic [D-1:0] a, input logic [W-1:0] v);
    bus.RegWrite   = 1'b1;
    bus.writeReg   = a;
    bus.writeValue = v;
    tick();
    bus.RegWrite   = 1'b0;
  endtask

  task automatic read1(input logic [D-1:0] a, output logic [W-1:0] v);
    bus.R1 = a;
    #1;
    v = bus.val1;
  endtask

  // Counts busy cycles from 'start' until IDLE, then checks the done pulse.
  task automatic wait_done(input string tag, input int start);
    int cyc;
    cyc = start;
    while (bus.busy === 1'b1 && cyc < 64) begin
      cyc++;
      tick();
    end
    sb_check({tag, "_busy_cycles"}, cyc);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
    tick();
    chk({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] v2;
    bit           done_seen;

    Reset          = 1'b1;
    bus.RegWrite   = 1'b0;
    bus.writeReg   = '0;
    bus.writeValue = '0;
    bus.R1         = '0;
    bus.R2         = '0;
    bus.saveReq    = 1'b0;
    bus.restoreReq = 1'b0;
    #12;

    for (int i = 0; i < N; i++) begin
      read1(4'(i), v);
      chk($sformatf("reset_read_r%0d", i), 32'(v), 32'h0);
    end
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_wrdropped", 32'(bus.wrDropped), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    tick();

    // Save r3=0x5A, overwrite, restore.
    write_reg(4'd3, 8'h5A);
    bus.saveReq = 1'b1;
    sb_push(32'd16);
    tick();
    bus.saveReq = 1'b0;
    wait_done("save1", 0);
    write_reg(4'd3, 8'h11);
    read1(4'd3, v);
    chk("r3_overwritten", 32'(v), 32'h11);
    bus.restoreReq = 1'b1;
    sb_push(32'd16);
    sb_push(32'h5A);
    tick();
    bus.restoreReq = 1'b0;
    wait_done("restore1", 0);
    read1(4'd3, v);
    sb_check("r3_restored", 32'(v));

    // Simultaneous save and restore: save wins.
    write_reg(4'd7, 8'h22);
    bus.saveReq    = 1'b1;
    bus.restoreReq = 1'b1;
    sb_push(32'd16);
    sb_push(32'h22);
    tick();
    bus.saveReq    = 1'b0;
    bus.restoreReq = 1'b0;
    wait_done("both_req", 0);
    read1(4'd7, v);
    sb_check("r7_after_save_win", 32'(v));
    write_reg(4'd7, 8'h33);
    bus.restoreReq = 1'b1;
    sb_push(32'd16);
    sb_push(32'h22);
    tick();
    bus.restoreReq = 1'b0;
    wait_done("restore2", 0);
    read1(4'd7, v);
    sb_check("r7_restored", 32'(v));

    // Write coincident with save, then a dropped write and ignored save while busy.
    bus.RegWrite   = 1'b1;
    bus.writeReg   = 4'd2;
    bus.writeValue = 8'h44;
    bus.saveReq    = 1'b1;
    sb_push(32'd16);
    tick();
    bus.RegWrite   = 1'b0;
    bus.saveReq    = 1'b0;
    repeat (4) tick();
    bus.RegWrite   = 1'b1;
    bus.writeReg   = 4'd2;
    bus.writeValue = 8'hFF;
    tick();
    bus.RegWrite   = 1'b0;
    chk("wrdropped_pulse", 32'(bus.wrDropped), 32'd1);
    read1(4'd2, v);
    chk("r2_unchanged_busy", 32'(v), 32'h44);
    bus.saveReq = 1'b1;
    tick();
    bus.saveReq = 1'b0;
    chk("wrdropped_one_cycle", 32'(bus.wrDropped), 32'd0);
    wait_done("save_busy", 6);
    write_reg(4'd2, 8'h00);
    bus.restoreReq = 1'b1;
    sb_push(32'd16);
    sb_push(32'h44);
    tick();
    bus.restoreReq = 1'b0;
    wait_done("restore3", 0);
    read1(4'd2, v);
    sb_check("r2_saved_with_write", 32'(v));

    // Partial restore visibility, then reset in the middle of it.
    write_reg(4'd2, 8'h10);
    write_reg(4'd9, 8'h99);
    bus.restoreReq = 1'b1;
    tick();
    bus.restoreReq = 1'b0;
    repeat (3) tick();
    bus.R2 = 4'd9;
    read1(4'd2, v);
    v2 = bus.val2;
    chk("partial_low_from_shadow", 32'(v), 32'h44);
    chk("partial_high_old_active", 32'(v2), 32'h99);
    repeat (5) tick();
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    chk("abort_r2_cleared", 32'(bus.val1), 32'h0);
    chk("abort_r9_cleared", 32'(bus.val2), 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    chk("abort_stays_idle", 32'(done_seen), 32'd0);
    write_reg(4'd3, 8'h5A);
    bus.restoreReq = 1'b1;
    sb_push(32'd16);
    sb_push(32'h0);
    tick();
    bus.restoreReq = 1'b0;
    wait_done("restore_after_reset", 0);
    read1(4'd3, v);
    sb_check("shadow_cleared_by_reset", 32'(v));

    // Same-cycle read of a register being written.
    write_reg(4'd4, 8'h12);
    bus.R1         = 4'd4;
    bus.writeReg   = 4'd4;
    bus.writeValue = 8'h3C;
    bus.RegWrite   = 1'b1;
`ifdef REG_FILE_BANKED_BYPASS_EN
    sb_push(32'h3C);
`else
    sb_push(32'h12);
`endif
    #1;
    sb_check("same_cycle_read", 32'(bus.val1));
    tick();
    bus.RegWrite = 1'b0;
    #1;
    chk("post_edge_read", 32'(bus.val1), 32'h3C);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0 leftover entries", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_file_banked.md
REG_FILE_BANKED -- requirements
Module: reg_file_banked

Interface
REQ-001 SHALL have parameter W, default 8, register width in bits.
REQ-002 SHALL have parameter D, default 4, address width; register count N = 2^D.
REQ-003 SHALL have port CLK  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RegWrite  input  1  write enable for active bank.
REQ-006 SHALL have port writeReg  input  D  write address.
REQ-007 SHALL have port writeValue  input  W  write data.
REQ-008 SHALL have ports R1, R2  input  D  read addresses.
REQ-009 SHALL have ports val1, val2  output  W  combinational read data from active bank.
REQ-010 SHALL have port saveReq  input  1  request copy of active bank into shadow bank.
REQ-011 SHALL have port restoreReq  input  1  request copy of shadow bank into active bank.
REQ-012 SHALL have port busy  output  1  high while a save or restore is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a save or restore completes.
REQ-014 SHALL have port wrDropped  output  1  one-cycle pulse when a write was rejected.

Function
REQ-015 SHALL hold two banks (active, shadow) of N registers of W bits each.
REQ-016 val1/val2 SHALL equal active[R1]/active[R2] combinationally, in every state.
REQ-017 SHALL implement FSM states IDLE, SAVE, RESTORE; busy = (state != IDLE).
REQ-018 In IDLE, RegWrite=1 SHALL write active[writeReg] <= writeValue at the rising edge.
REQ-019 In IDLE, saveReq=1 SHALL go to SAVE with index counter cnt=0; restoreReq=1 (saveReq=0) SHALL go to RESTORE with cnt=0.
REQ-020 Simultaneous saveReq and restoreReq in IDLE: SAVE SHALL win; restoreReq is discarded.
REQ-021 A cycle with RegWrite=1 and a request in IDLE SHALL perform the write first; the save SHALL capture the written value.
REQ-022 Each SAVE cycle SHALL copy shadow[cnt] <= active[cnt] and increment cnt; each RESTORE cycle SHALL copy active[cnt] <= shadow[cnt] and increment cnt.
REQ-023 When cnt = N-1 is copied, the FSM SHALL return to IDLE and cnt SHALL wrap to 0; busy SHALL be high for exactly N cycles.
REQ-024 done SHALL be high for exactly one cycle, the first IDLE cycle after completion.
REQ-025 saveReq/restoreReq while busy SHALL be ignored (not queued).
REQ-026 RegWrite while busy SHALL NOT modify either bank; wrDropped SHALL pulse high in the following cycle.
REQ-027 During RESTORE, reads SHALL return the partially restored contents: entries below cnt come from shadow, the rest are old active values.

Reset
REQ-028 Reset=1 SHALL, asynchronously, clear all active and shadow entries to 0, state to IDLE, cnt to 0, and busy, done and wrDropped to 0.
REQ-029 Reset asserted mid-SAVE/RESTORE SHALL abort the operation without a done pulse; the first edge after deassertion SHALL be treated as IDLE.

Configuration
REQ-030 Macro REG_FILE_BANKED_BYPASS_EN defined: when a write is accepted (IDLE, RegWrite=1) and R1 or R2 equals writeReg, that port SHALL return writeValue in the same cycle.
REQ-031 Macro undefined: reads SHALL return the pre-write value until the next edge; no bypass logic is present.

Verification (W=8, D=4, N=16)
REQ-032 Reset, then read all 16 addresses -> all 0; busy=0, done=0, wrDropped=0.
REQ-033 Write r3=0x5A, saveReq pulse, then write r3=0x11 after done, restoreReq -> after 16 busy cycles and a done pulse, val1(R1=3)=0x5A.
REQ-034 saveReq and restoreReq together in IDLE with r7=0x22, shadow r7=0 -> SAVE runs; after done, a restore leaves r7=0x22.
REQ-035 RegWrite r2=0xFF on cycle 5 of SAVE -> r2 unchanged, wrDropped pulses one cycle; a second saveReq during busy -> no extra busy cycles.
REQ-036 Reset asserted at cnt=8 of RESTORE -> both banks 0, busy falls immediately, no done pulse.
REQ-037 R1=writeReg=4, writeValue=0x3C, RegWrite=1 in IDLE -> val1=0x3C in the same cycle with REG_FILE_BANKED_BYPASS_EN, old value without it.
